cpu_io_hub: RTL

- Parametrised memory-mapped I/O unit for the CPU.
- Replaces the fixed per-peripheral ports (VGA start/row registers, serial strobes, gamepad, timer) with one address-decoded window of NUM_OUT general output registers.
- Adds a buffered serial receive FIFO, a handshaked serial transmitter, a prescaled timer and an interrupt line.
- Sits beside data memory on the CPU's address/data bus. The CPU top uses Io_Sel to steer reads and suppress memory writes.

---
 rtl/cpu_io_pkg.sv | 29 ++
 rtl/io_rx_fifo.sv | 55 +++++
 rtl/cpu_io_hub.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU memory-mapped I/O hub.
// Register offsets beyond the output registers are relative to NUM_OUT:
// absolute offset = NUM_OUT + OFF_xxx (see io_off()).
package cpu_io_pkg;

  localparam int unsigned OFF_RXDATA = 0;
  localparam int unsigned OFF_STATUS = 1;
  localparam int unsigned OFF_TXDATA = 2;
  localparam int unsigned OFF_PAD    = 3;
  localparam int unsigned OFF_TIMER  = 4;
  localparam int unsigned OFF_CTRL   = 5;

  // STATUS register bit positions
  localparam int unsigned ST_NONEMPTY = 0;
  localparam int unsigned ST_FULL     = 1;
  localparam int unsigned ST_OVF      = 2;
  localparam int unsigned ST_TXBUSY   = 3;
  localparam int unsigned ST_CNT_LSB  = 4;
  localparam int unsigned ST_CNT_W    = 4;

  // CTRL register bit positions
  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_OVF_CLR = 1;

  function automatic int unsigned io_off(int unsigned num_out, int unsigned rel);
    return num_out + rel;
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Serial receive FIFO.
// Ports: clk_i/rst_ni (sync active-low), push/din enqueue, pop dequeues,
// dout shows the head word, count/full/empty report occupancy,
// ovf_pulse is high for a push that had to be dropped.
// A push while full is accepted when a pop happens in the same cycle.
module io_rx_fifo
  import cpu_io_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign ovf_pulse = push && full && !do_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cpu_io_hub.sv
// Memory-mapped I/O hub on the CPU address/data bus.
// Ports: Clock/Reset (sync active-low); Cpu_Addr/Cpu_Write/Cpu_Read/
// Cpu_WData bus inputs, Cpu_RData registered read data, Io_Sel window hit;
// Out_Regs packed general output registers; SerialValid/SerialRead receive
// side; SerialWrite/SerialData/SerialReady transmit handshake; GamePad
// buttons; Irq registered interrupt (irq_en & rx not empty).
module cpu_io_hub
  import cpu_io_pkg::*;
#(
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]   IO_BASE   = 16'hFF00,
  parameter int unsigned         NUM_OUT   = 2,
  parameter int unsigned         RX_DEPTH  = 8,
  parameter int unsigned         TIMER_DIV = 50000
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [ADDR_W-1:0]         Cpu_Addr,
  input  logic                      Cpu_Write,
  input  logic                      Cpu_Read,
  input  logic [DATA_W-1:0]         Cpu_WData,
  output logic [DATA_W-1:0]         Cpu_RData,
  output logic                      Io_Sel,
  output logic [NUM_OUT*DATA_W-1:0] Out_Regs,
  input  logic                      SerialValid,
  input  logic [DATA_W-1:0]         SerialRead,
  output logic                      SerialWrite,
  output logic [DATA_W-1:0]         SerialData,
  input  logic                      SerialReady,
  input  logic [7:0]                GamePad,
  output logic                      Irq
);

  localparam int unsigned CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [ADDR_W-1:0] A_RX    = ADDR_W'(io_off(NUM_OUT, OFF_RXDATA));
  localparam logic [ADDR_W-1:0] A_ST    = ADDR_W'(io_off(NUM_OUT, OFF_STATUS));
  localparam logic [ADDR_W-1:0] A_TX    = ADDR_W'(io_off(NUM_OUT, OFF_TXDATA));
  localparam logic [ADDR_W-1:0] A_PAD   = ADDR_W'(io_off(NUM_OUT, OFF_PAD));
  localparam logic [ADDR_W-1:0] A_TIMER = ADDR_W'(io_off(NUM_OUT, OFF_TIMER));
  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(io_off(NUM_OUT, OFF_CTRL));

  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_req_q, tx_req_d;
  logic [DATA_W-1:0] timer_q, timer_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic [ADDR_W-1:0] off;
  logic              in_win, wr_en, rd_en;
  logic              rx_pop, rx_full, rx_empty, rx_ovf;
  logic [DATA_W-1:0] rx_dout;
  logic [CW-1:0]     rx_count, cnt_next;
  logic              push_acc;
  logic [DATA_W-1:0] status;

  assign off    = Cpu_Addr - IO_BASE;
  assign in_win = (Cpu_Addr >= IO_BASE) && (off <= A_CTRL);
  assign Io_Sel = in_win;
  assign wr_en  = Cpu_Write && in_win;
  assign rd_en  = Cpu_Read && !Cpu_Write && in_win;
  assign rx_pop = rd_en && (off == A_RX) && !rx_empty;

  io_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i     (Clock),
    .rst_ni    (Reset),
    .push      (SerialValid),
    .pop       (rx_pop),
    .din       (SerialRead),
    .dout      (rx_dout),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .ovf_pulse (rx_ovf)
  );

  // Irq is registered from next-state occupancy, so mirror the FIFO's
  // accept rule here to know whether it will be non-empty after this edge.
  assign push_acc = SerialValid && (!rx_full || rx_pop);
  assign cnt_next = rx_count + CW'(push_acc) - CW'(rx_pop);

  always_comb begin
    status                            = '0;
    status[ST_NONEMPTY]               = !rx_empty;
    status[ST_FULL]                   = rx_full;
    status[ST_OVF]                    = ovf_q;
    status[ST_TXBUSY]                 = tx_req_q;
    status[ST_CNT_LSB +: ST_CNT_W]    = (int'(rx_count) > 15) ? 4'hF : 4'(rx_count);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (off == ADDR_W'(k)) rdata_d = out_q[k];
      if (off == A_RX && !rx_empty) rdata_d = rx_dout;
      if (off == A_ST)              rdata_d = status;
      if (off == A_PAD)             rdata_d = DATA_W'(GamePad);
      if (off == A_TIMER)           rdata_d = timer_q;
      if (off == A_CTRL)            rdata_d = DATA_W'(irq_en_q);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && off == A_CTRL && Cpu_WData[CTRL_OVF_CLR]) ovf_d = 1'b0;
    if (rx_ovf) ovf_d = 1'b1;

    irq_en_d = irq_en_q;
    if (wr_en && off == A_CTRL) irq_en_d = Cpu_WData[CTRL_IRQ_EN];
    irq_d = irq_en_d && (cnt_next != '0);

    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    if (wr_en && off == A_TX && !tx_req_q) begin
      tx_req_d  = 1'b1;
      tx_data_d = Cpu_WData;
    end else if (tx_req_q && SerialReady) begin
      tx_req_d = 1'b0;
    end

    timer_d = timer_q;
    presc_d = presc_q + PW'(1);
    if (wr_en && off == A_TIMER) begin
      timer_d = Cpu_WData;
      presc_d = '0;
    end else if (presc_q == PW'(TIMER_DIV - 1)) begin
      timer_d = timer_q + DATA_W'(1);
      presc_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      rdata_q   <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      timer_q   <= '0;
      presc_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (wr_en && off == ADDR_W'(k)) out_q[k] <= Cpu_WData;
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    Out_Regs = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      Out_Regs[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign Cpu_RData   = rdata_q;
  assign SerialWrite = tx_req_q;
  assign SerialData  = tx_data_q;
  assign Irq         = irq_q;

endmodule
